// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int unsigned CLK_DIV_MIN = 2;

  // The high phase H is the divisor shifted right by this amount.
  localparam int unsigned CLK_DIV_HALF_SHIFT = 1;

  function automatic int unsigned clk_div_clamp(input int unsigned value);
    return (value < CLK_DIV_MIN) ? CLK_DIV_MIN : value;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Divider counter: wrap/fall compare plus registered clk_out and tick for a given divisor.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             force_wrap,
  input  logic [WIDTH-1:0] cur_div,
  output logic             wrap,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] last_cnt;
  logic [WIDTH-1:0] fall_cnt;

  assign last_cnt = cur_div - One;
  assign fall_cnt = (cur_div >> CLK_DIV_HALF_SHIFT) - One;
  assign wrap     = en & (force_wrap | (count_q == last_cnt));

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= wrap;
      if (wrap) begin
        count_q <= '0;
        clk_out <= 1'b1;
      end else if (en) begin
        count_q <= count_q + One;
        if (count_q == fall_cnt) begin
          clk_out <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider: shadowed divisor applied at period boundaries.
// Optional CLK_DIV_SYNC_EN adds a `sync` input that forces an immediate wrap.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
`ifdef CLK_DIV_SYNC_EN
  input  logic             sync,
`endif
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             div_pending,
  output logic             div_err,
  output logic [WIDTH-1:0] cur_div
);

  localparam logic [WIDTH-1:0] ResetDiv = WIDTH'(RESET_DIV);

  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] div_clamped;
  logic             clamp_hit;
  logic             force_wrap;
  logic             wrap;

`ifdef CLK_DIV_SYNC_EN
  assign force_wrap = sync;
`else
  assign force_wrap = 1'b0;
`endif

  assign div_clamped = WIDTH'(clk_div_clamp(32'(div_in)));
  assign clamp_hit   = (div_clamped != div_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_div     <= ResetDiv;
      shadow_q    <= ResetDiv;
      div_pending <= 1'b0;
      div_err     <= 1'b0;
    end else begin
      div_err <= div_load & clamp_hit;
      if (div_load) begin
        shadow_q <= div_clamped;
        // A load landing on the wrap edge bypasses the shadow stage entirely.
        if (wrap) begin
          cur_div     <= div_clamped;
          div_pending <= 1'b0;
        end else begin
          div_pending <= 1'b1;
        end
      end else if (wrap && div_pending) begin
        cur_div     <= shadow_q;
        div_pending <= 1'b0;
      end
    end
  end

  clk_div_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .force_wrap(force_wrap),
    .cur_div   (cur_div),
    .wrap      (wrap),
    .clk_out   (clk_out),
    .tick      (tick)
  );

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog against a period/phase reference model.
module tb_clk_div_prog;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned RESET_DIV = 4;

  logic             clk      = 1'b0;
  logic             reset    = 1'b1;
  logic             en       = 1'b0;
  logic             div_load = 1'b0;
  logic             sync     = 1'b0;
  logic [WIDTH-1:0] div_in   = '0;
  logic             clk_out, tick, div_pending, div_err;
  logic [WIDTH-1:0] cur_div;

  int total = 0;
  int bad   = 0;

  // Model: position within the current period, active period length, first-period flag.
  int m_pos, m_n, m_shadow;
  bit m_first, m_pend, m_err, m_tick, m_out;

  clk_div_prog #(
    .WIDTH    (WIDTH),
    .RESET_DIV(RESET_DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
`ifdef CLK_DIV_SYNC_EN
    .sync       (sync),
`endif
    .div_in     (div_in),
    .div_load   (div_load),
    .clk_out    (clk_out),
    .tick       (tick),
    .div_pending(div_pending),
    .div_err    (div_err),
    .cur_div    (cur_div)
  );

  always #5 clk = ~clk;

  wire [WIDTH+3:0] obs = {clk_out, tick, div_pending, div_err, cur_div};

  function automatic logic [WIDTH+3:0] mexp();
    return {m_out, m_tick, m_pend, m_err, WIDTH'(m_n)};
  endfunction

  task automatic model_step();
    bit w;
    bit do_sync;
    int cv;
`ifdef CLK_DIV_SYNC_EN
    do_sync = sync;
`else
    do_sync = 1'b0;
`endif
    if (reset) begin
      m_pos = 0; m_first = 1; m_n = RESET_DIV; m_shadow = RESET_DIV;
      m_pend = 0; m_err = 0; m_tick = 0; m_out = 0;
      return;
    end
    w = en && (do_sync || m_pos == m_n - 1);
    cv = (div_in < 2) ? 2 : int'(div_in);
    m_err  = div_load && (div_in < 2);
    m_tick = w;
    if (w) begin
      m_pos = 0; m_first = 0;
    end else if (en) begin
      m_pos++;
    end
    if (div_load) begin
      m_shadow = cv;
      if (w) begin m_n = cv; m_pend = 0; end
      else m_pend = 1;
    end else if (w && m_pend) begin
      m_n = m_shadow; m_pend = 0;
    end
    // Waveform rule: high for the first N>>1 cycles of every period except the first.
    m_out = !m_first && (m_pos < m_n / 2);
  endtask

  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [WIDTH+3:0] rst_exp;
    rst_exp = {4'b0000, WIDTH'(RESET_DIV)};
    reset = 1'b1; en = 1'b0; div_load = 1'b0;
    adv(); adv();
    total++;
    if (obs !== rst_exp) begin
      bad++; $display("FAIL reset_values got=%h want=%h", obs, rst_exp);
    end
    total++;
    if (obs !== mexp()) begin
      bad++; $display("FAIL reset_model got=%h want=%h", obs, mexp());
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [11:0] pat;
    logic [11:0] tpat;
    pat  = 12'b000110011001;
    tpat = 12'b000100010001;
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      adv();
      total++;
      if (clk_out !== pat[11-i] || tick !== tpat[11-i]) begin
        bad++; $display("FAIL basic_pattern cyc=%0d got clk_out=%b tick=%b want %b %b",
                        i, clk_out, tick, pat[11-i], tpat[11-i]);
      end
      total++;
      if (obs !== mexp()) begin
        bad++; $display("FAIL basic_model cyc=%0d got=%h want=%h", i, obs, mexp());
      end
    end
  endtask

  task automatic test_load();
    adv();
    div_in = 8'd5; div_load = 1'b1;
    adv();
    div_load = 1'b0;
    total++;
    if (div_pending !== 1'b1) begin
      bad++; $display("FAIL load_pending got=%b want=1", div_pending);
    end
    for (int i = 0; i < 16; i++) begin
      adv();
      total++;
      if (obs !== mexp()) begin
        bad++; $display("FAIL load_model cyc=%0d got=%h want=%h", i, obs, mexp());
      end
    end
    total++;
    if (cur_div !== 8'd5 || div_pending !== 1'b0) begin
      bad++; $display("FAIL load_applied got div=%0d pend=%b want 5 0", cur_div, div_pending);
    end
  endtask

  task automatic test_clamp();
    logic [WIDTH-1:0] vals [2];
    vals[0] = 8'd0; vals[1] = 8'd1;
    for (int v = 0; v < 2; v++) begin
      div_in = vals[v]; div_load = 1'b1;
      adv();
      div_load = 1'b0;
      total++;
      if (div_err !== 1'b1 || obs !== mexp()) begin
        bad++; $display("FAIL clamp_err_pulse v=%0d got=%h want=%h", v, obs, mexp());
      end
      adv();
      total++;
      if (div_err !== 1'b0) begin
        bad++; $display("FAIL clamp_err_clear v=%0d got=%b want=0", v, div_err);
      end
    end
    for (int i = 0; i < 12; i++) begin
      adv();
      total++;
      if (obs !== mexp()) begin
        bad++; $display("FAIL clamp_model cyc=%0d got=%h want=%h", i, obs, mexp());
      end
    end
    total++;
    if (cur_div !== 8'd2) begin
      bad++; $display("FAIL clamp_div got=%0d want=2", cur_div);
    end
  endtask

  task automatic test_load_at_wrap();
    int k = 0;
    while (m_pos != m_n - 1 && k < 40) begin adv(); k++; end
    total++;
    if (m_pos != m_n - 1) begin
      bad++; $display("FAIL wrap_wait_timeout got pos=%0d want %0d", m_pos, m_n - 1);
    end
    div_in = 8'd7; div_load = 1'b1;
    adv();
    div_load = 1'b0;
    total++;
    if (div_pending !== 1'b0 || cur_div !== 8'd7 || tick !== 1'b1) begin
      bad++; $display("FAIL wrap_load got pend=%b div=%0d tick=%b want 0 7 1",
                      div_pending, cur_div, tick);
    end
  endtask

  task automatic test_overwrite();
    div_in = 8'd6; div_load = 1'b1;
    adv();
    div_in = 8'd3;
    adv();
    div_load = 1'b0;
    total++;
    if (div_pending !== 1'b1 || cur_div !== 8'd7) begin
      bad++; $display("FAIL overwrite_pending got pend=%b div=%0d want 1 7", div_pending, cur_div);
    end
    for (int i = 0; i < 20; i++) begin
      adv();
      total++;
      if (obs !== mexp()) begin
        bad++; $display("FAIL overwrite_model cyc=%0d got=%h want=%h", i, obs, mexp());
      end
    end
    total++;
    if (cur_div !== 8'd3) begin
      bad++; $display("FAIL overwrite_div got=%0d want=3", cur_div);
    end
  endtask

  task automatic test_en_hold();
    int k = 0;
    div_in = 8'd6; div_load = 1'b1;
    adv();
    div_load = 1'b0;
    while (!(m_n == 6 && m_pos == 0) && k < 40) begin adv(); k++; end
    total++;
    if (!(m_n == 6 && m_pos == 0)) begin
      bad++; $display("FAIL hold_wait_timeout got n=%0d pos=%0d want 6 0", m_n, m_pos);
    end
    adv();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      adv();
      total++;
      if (clk_out !== 1'b1 || tick !== 1'b0 || obs !== mexp()) begin
        bad++; $display("FAIL hold_frozen cyc=%0d got=%h want=%h", i, obs, mexp());
      end
    end
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      adv();
      total++;
      if (obs !== mexp()) begin
        bad++; $display("FAIL hold_resume cyc=%0d got=%h want=%h", i, obs, mexp());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH+3:0] rst_exp;
    rst_exp = {4'b0000, WIDTH'(RESET_DIV)};
    div_in = 8'd9; div_load = 1'b1;
    adv();
    div_load = 1'b0;
    reset = 1'b1;
    adv();
    reset = 1'b0;
    total++;
    if (obs !== rst_exp) begin
      bad++; $display("FAIL reset_mid got=%h want=%h", obs, rst_exp);
    end
    for (int i = 0; i < 10; i++) begin
      adv();
      total++;
      if (obs !== mexp()) begin
        bad++; $display("FAIL reset_mid_model cyc=%0d got=%h want=%h", i, obs, mexp());
      end
    end
  endtask

`ifdef CLK_DIV_SYNC_EN
  task automatic test_sync();
    int k = 0;
    div_in = 8'd8; div_load = 1'b1;
    adv();
    div_load = 1'b0;
    while (!(m_n == 8 && m_pos == 2) && k < 60) begin adv(); k++; end
    total++;
    if (!(m_n == 8 && m_pos == 2)) begin
      bad++; $display("FAIL sync_wait_timeout got n=%0d pos=%0d want 8 2", m_n, m_pos);
    end
    sync = 1'b1;
    adv();
    sync = 1'b0;
    total++;
    if (tick !== 1'b1 || clk_out !== 1'b1 || obs !== mexp()) begin
      bad++; $display("FAIL sync_wrap got=%h want=%h", obs, mexp());
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(7) != 0);
      div_load = ($urandom_range(7) == 0);
      div_in   = WIDTH'($urandom_range(9));
      reset    = ($urandom_range(99) == 0);
`ifdef CLK_DIV_SYNC_EN
      sync     = ($urandom_range(29) == 0);
`endif
      adv();
      total++;
      if (obs !== mexp()) begin
        bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, mexp());
      end
    end
    reset = 1'b0; div_load = 1'b0; sync = 1'b0; en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load();
    test_clamp();
    test_load_at_wrap();
    test_overwrite();
    test_en_hold();
    test_reset_mid();
`ifdef CLK_DIV_SYNC_EN
    test_sync();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
